// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Round-robin arbiter that shares one SDRAM controller command port among
//   NPORTS requesters. One command is in flight on the command port at a time.
//   Outstanding reads are remembered in a small tag FIFO so that each returned
//   read word is steered back to the port that asked for it.
//
// Ports
//   CLOCK_100            clock, all logic on the rising edge
//   rst                  asynchronous active-high reset
//   req_valid/req_we     per-port request and write flag (1=write, 0=read)
//   req_addr/req_wdata   packed per-port address/data, port i at [i*W +: W]
//   req_ready            one-hot; the request of that port is taken this cycle
//   rsp_valid/rsp_data   one-hot read-return strobe plus shared read data
//   mem_valid/mem_ready  command handshake towards the controller
//   mem_we/addr/wdata    command payload, held stable while mem_valid=1
//   mem_rvalid/rdata     read data from the controller, in command order
//   pending              number of reads issued but not yet returned
//   rsp_err              sticky: read data arrived with no read outstanding
module sdram_port_arbiter #(
  parameter int NPORTS = 4,
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int RDEPTH = 4
) (
  input  logic                      CLOCK_100,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req_valid,
  input  logic [NPORTS-1:0]         req_we,
  input  logic [NPORTS*AW-1:0]      req_addr,
  input  logic [NPORTS*DW-1:0]      req_wdata,
  output logic [NPORTS-1:0]         req_ready,
  output logic [NPORTS-1:0]         rsp_valid,
  output logic [DW-1:0]             rsp_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic                      mem_rvalid,
  input  logic [DW-1:0]             mem_rdata,
  output logic [$clog2(RDEPTH):0]   pending,
  output logic                      rsp_err
);

  localparam int PW = $clog2(NPORTS);
  localparam int FW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH) + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       rr_last_q, rr_last_d;
  logic [PW-1:0]       g_q, g_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic [NPORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CW-1:0]       pending_q, pending_d;
  logic [FW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]       rd_ptr_q, rd_ptr_d;

  logic [AW-1:0]       port_addr  [NPORTS];
  logic [DW-1:0]       port_wdata [NPORTS];
  logic [NPORTS-1:0]   eligible;
  logic                read_room;
  logic                grant_found;
  logic [PW-1:0]       grant_idx;
  logic [NPORTS-1:0]   req_ready_c;
  logic                push;
  logic                pop;

  // Tags of outstanding reads, oldest at rd_ptr_q.
  logic [PW-1:0]       tag_mem [RDEPTH];

  // Reads are only offered while a tag slot is free; writes never need one.
  assign read_room = (pending_q < CW'(RDEPTH));

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    assign port_addr[gi]  = req_addr[gi*AW +: AW];
    assign port_wdata[gi] = req_wdata[gi*DW +: DW];
    assign eligible[gi]   = req_valid[gi] & (req_we[gi] | read_room);
  end

  // Search starts just after the last granted port so every waiting port is
  // served before any port is served twice.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      if (!grant_found && eligible[(int'(rr_last_q) + k) % NPORTS]) begin
        grant_found = 1'b1;
        grant_idx   = PW'((int'(rr_last_q) + k) % NPORTS);
      end
    end
  end

  // In ISSUE mem_valid is always high, so mem_ready alone completes the command.
  assign push = (state_q == S_ISSUE) && mem_ready && !mem_we_q;
  // Read data only pops a tag when one exists; otherwise it is flagged.
  assign pop  = mem_rvalid && (pending_q != '0);

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    g_d         = g_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready_c = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready_c = NPORTS'(1) << grant_idx;
          g_d         = grant_idx;
          mem_valid_d = 1'b1;
          mem_we_d    = req_we[grant_idx];
          mem_addr_d  = port_addr[grant_idx];
          mem_wdata_d = port_wdata[grant_idx];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rr_last_d   = g_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == FW'(RDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == FW'(RDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    pending_d = pending_q + CW'(push) - CW'(pop);

    rsp_valid_d = pop ? (NPORTS'(1) << tag_mem[rd_ptr_q]) : '0;
    rsp_data_d  = pop ? mem_rdata : rsp_data_q;
    rsp_err_d   = rsp_err_q | (mem_rvalid && (pending_q == '0));
  end

  always_ff @(posedge CLOCK_100 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_last_q   <= PW'(NPORTS - 1);
      g_q         <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      pending_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      g_q         <= g_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      pending_q   <= pending_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLOCK_100) begin
    if (push) tag_mem[wr_ptr_q] <= g_q;
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pending   = pending_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed scenarios followed by a randomized phase, all checked every cycle
//   against a transaction-level reference: round-robin search over waiting
//   ports, a queue of outstanding read owners, and the expected read return.
module tb_sdram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_we;
  logic [95:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [3:0]   req_ready, rsp_valid;
  logic [15:0]  rsp_data;
  logic         mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [23:0]  mem_addr;
  logic [15:0]  mem_wdata, mem_rdata;
  logic [2:0]   pending;
  logic         rsp_err;

  sdram_port_arbiter #(.NPORTS(4), .AW(24), .DW(16), .RDEPTH(4)) dut (
    .CLOCK_100(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .pending(pending), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state
  int          rr_last;
  bit          busy;
  int          cur_port;
  bit          cur_we;
  logic [23:0] cur_addr;
  logic [15:0] cur_wdata;
  int          tagq[$];
  bit          rsp_pend;
  int          rsp_port;
  logic [15:0] last_rsp_data;
  bit          err;

  // Observed DUT events for directed constant checks
  int          obs_grants[$];
  int          obs_rsp_port[$];
  logic [15:0] obs_rsp_data[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int p, input bit we, input logic [23:0] a, input logic [15:0] d);
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*24 +: 24] = a;
    req_wdata[p*16 +: 16] = d;
  endtask

  // One clock cycle: compare at the falling edge, advance the reference,
  // then move to just after the rising edge where stimulus is changed.
  task automatic step();
    int g;
    logic [3:0] elig;
    @(negedge clk);
    g = -1;
    elig = '0;
    if (!busy) begin
      for (int i = 0; i < 4; i++) elig[i] = req_valid[i] & (req_we[i] | (tagq.size() < 4));
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (rr_last + k) % 4;
        if (g < 0 && elig[idx]) g = idx;
      end
    end
    for (int i = 0; i < 4; i++) if (req_ready[i]) obs_grants.push_back(i);
    for (int i = 0; i < 4; i++) if (rsp_valid[i]) begin
      obs_rsp_port.push_back(i);
      obs_rsp_data.push_back(rsp_data);
    end
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
    chk("mem_valid", 64'(mem_valid), 64'(busy));
    if (busy) begin
      chk("mem_we", 64'(mem_we), 64'(cur_we));
      chk("mem_addr", 64'(mem_addr), 64'(cur_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
    end
    chk("pending", 64'(pending), 64'(tagq.size()));
    chk("rsp_valid", 64'(rsp_valid), rsp_pend ? 64'(4'b0001 << rsp_port) : 64'd0);
    chk("rsp_data", 64'(rsp_data), 64'(last_rsp_data));
    chk("rsp_err", 64'(rsp_err), 64'(err));
    // read return uses the outstanding set as it stood before this edge
    rsp_pend = 1'b0;
    if (mem_rvalid) begin
      if (tagq.size() > 0) begin
        rsp_pend = 1'b1;
        rsp_port = tagq.pop_front();
        last_rsp_data = mem_rdata;
      end else begin
        err = 1'b1;
      end
    end
    if (busy) begin
      if (mem_ready) begin
        if (!cur_we) tagq.push_back(cur_port);
        rr_last = cur_port;
        busy = 1'b0;
      end
    end else if (g >= 0) begin
      busy = 1'b1;
      cur_port = g;
      cur_we = req_we[g];
      cur_addr = req_addr[g*24 +: 24];
      cur_wdata = req_wdata[g*16 +: 16];
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    mem_rvalid = 1'b0;
    mem_ready = 1'b0;
    busy = 1'b0;
    rr_last = 3;
    tagq.delete();
    rsp_pend = 1'b0;
    last_rsp_data = '0;
    err = 1'b0;
    obs_grants.delete();
    obs_rsp_port.delete();
    obs_rsp_data.delete();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;

    // 1: single read from port 0 and its return
    do_reset();
    mem_ready = 1'b1;
    post(0, 1'b0, 24'h000123, 16'h0000);
    step();
    step();
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 16'hBEEF;
    step();
    mem_rvalid = 1'b0;
    step();
    step();
    chk("t1_grant", 64'(obs_grants.size() == 1 ? obs_grants[0] : -1), 64'd0);
    chk("t1_rsp_port", 64'(obs_rsp_port.size() == 1 ? obs_rsp_port[0] : -1), 64'd0);
    chk("t1_rsp_data", 64'(obs_rsp_data.size() == 1 ? obs_rsp_data[0] : 16'h0), 64'hBEEF);

    // 2: all ports requesting continuously -> strict rotation
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < 4; p++) post(p, 1'b1, 24'(24'h100 + p), 16'(16'h10 * (p + 1)));
      step();
    end
    req_valid = '0;
    step();
    step();
    chk("t2_count", 64'(obs_grants.size()), 64'd6);
    begin
      int exp_g[6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++)
        chk("t2_order", 64'(i < obs_grants.size() ? obs_grants[i] : -1), 64'(exp_g[i]));
    end

    // 3: read slots exhausted; writes still pass, reads resume after a return
    do_reset();
    mem_ready = 1'b1;
    for (int p = 0; p < 4; p++) post(p, 1'b0, 24'(24'h200 + p), 16'h0);
    repeat (8) step();
    chk("t3_pending_full", 64'(pending), 64'd4);
    post(1, 1'b0, 24'h000301, 16'h0);
    post(2, 1'b1, 24'h000302, 16'h7777);
    step();
    step();
    chk("t3_read_stalled", 64'(req_valid[1]), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata = 16'hA000;
    step();
    mem_rvalid = 1'b0;
    step();
    step();
    chk("t3_write_grant", 64'(obs_grants.size() > 4 ? obs_grants[4] : -1), 64'd2);
    chk("t3_read_grant", 64'(obs_grants.size() > 5 ? obs_grants[5] : -1), 64'd1);
    for (int i = 0; i < 8 && tagq.size() > 0; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata = 16'(16'hA001 + i);
      step();
    end
    mem_rvalid = 1'b0;
    step();

    // 4: responses steered back in command order
    do_reset();
    mem_ready = 1'b1;
    post(3, 1'b0, 24'h000403, 16'h0);
    step();
    step();
    post(1, 1'b0, 24'h000401, 16'h0);
    step();
    step();
    mem_rvalid = 1'b1;
    mem_rdata = 16'h1111;
    step();
    mem_rdata = 16'h2222;
    step();
    mem_rvalid = 1'b0;
    step();
    step();
    chk("t4_rsp0_port", 64'(obs_rsp_port.size() > 0 ? obs_rsp_port[0] : -1), 64'd3);
    chk("t4_rsp0_data", 64'(obs_rsp_data.size() > 0 ? obs_rsp_data[0] : 16'h0), 64'h1111);
    chk("t4_rsp1_port", 64'(obs_rsp_port.size() > 1 ? obs_rsp_port[1] : -1), 64'd1);
    chk("t4_rsp1_data", 64'(obs_rsp_data.size() > 1 ? obs_rsp_data[1] : 16'h0), 64'h2222);

    // 5: controller stall holds the command and blocks new grants
    do_reset();
    post(0, 1'b1, 24'hABCDEF, 16'h5A5A);
    step();
    for (int p = 1; p < 4; p++) post(p, 1'b1, 24'(24'h500 + p), 16'(16'h500 + p));
    repeat (10) step();
    chk("t5_no_grant_in_stall", 64'(obs_grants.size()), 64'd1);
    chk("t5_held_addr", 64'(mem_addr), 64'hABCDEF);
    mem_ready = 1'b1;
    repeat (8) step();

    // 6: reset with reads outstanding and a command stalled
    do_reset();
    mem_ready = 1'b1;
    post(0, 1'b0, 24'h000600, 16'h0);
    post(1, 1'b0, 24'h000601, 16'h0);
    repeat (4) step();
    chk("t6_pending2", 64'(pending), 64'd2);
    post(2, 1'b0, 24'h000602, 16'h0);
    mem_ready = 1'b0;
    step();
    step();
    chk("t6_in_issue", 64'(mem_valid), 64'd1);
    do_reset();
    mem_rvalid = 1'b1;
    mem_rdata = 16'hDEAD;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("t6_err_sticky", 64'(rsp_err), 64'd1);
    chk("t6_no_rsp", 64'(obs_rsp_port.size()), 64'd0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++)
        if (!req_valid[p] && ($urandom % 4 == 0))
          post(p, 1'($urandom), 24'($urandom), 16'($urandom));
      mem_ready = ($urandom % 3) != 0;
      mem_rvalid = (tagq.size() > 0) && ($urandom % 2 == 1);
      mem_rdata = 16'($urandom);
      step();
    end
    req_valid = '0;
    mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      mem_rvalid = (tagq.size() > 0);
      mem_rdata = 16'($urandom);
      step();
    end
    mem_rvalid = 1'b0;
    step();
    chk("rand_drained", 64'(pending), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
